// File: rtl/m64282_seq_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : m64282_pkg
// Purpose  : Shared types and constants for the M64282FP capture sequencer.
//            State encoding, serial register frame geometry and a helper that
//            picks one bit of an address/data register frame, MSB first.
// Revision : 1.0 - initial release
// ============================================================================
package m64282_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RST     = 3'd1,
        LOAD    = 3'd2,
        START   = 3'd3,
        EXPOSE  = 3'd4,
        READOUT = 3'd5,
        DONE    = 3'd6
    } state_t;

    localparam int SER_BITS  = 11;  // 3 address bits + 8 data bits
    localparam int ADDR_BITS = 3;
    localparam int RST_XCK   = 2;   // XCK cycles with sensor RESET held low

    // Bit number idx (0 = first bit on the wire) of the frame {addr, data}.
    function automatic logic ser_bit(input logic [ADDR_BITS-1:0] addr,
                                     input logic [7:0]           data,
                                     input logic [3:0]           idx);
        logic [SER_BITS-1:0] w_word;
        w_word = {addr, data} << idx;
        return w_word[SER_BITS-1];
    endfunction

endpackage
`default_nettype wire

// File: rtl/m64282_seq_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : m64282_seq_if
// Purpose  : Host-side bundle of the capture sequencer: register image and
//            capture request in, busy/pixel stream/error flags out.
//            master = host / frame buffer side, slave = sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface m64282_seq_if #(
    parameter int NUM_REGS = 8,
    parameter int ADC_W    = 8
);
    logic [8*NUM_REGS-1:0] cfg_regs;
    logic                  cap_req;
    logic                  busy;
    logic                  pix_valid;
    logic [ADC_W-1:0]      pix_data;
    logic                  pix_last;
    logic                  err_timeout;
    logic                  err_short;

    modport master (
        output cfg_regs, cap_req,
        input  busy, pix_valid, pix_data, pix_last, err_timeout, err_short
    );

    modport slave (
        input  cfg_regs, cap_req,
        output busy, pix_valid, pix_data, pix_last, err_timeout, err_short
    );
endinterface
`default_nettype wire

// File: rtl/m64282_seq_xck_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : m64282_xck_gen
// Purpose  : Sensor clock divider. Counts 0..XCK_DIV-1 and toggles XCK on
//            wrap; rise/fall strobes are high in the sys-clock cycle whose
//            closing edge moves XCK to 1/0.
// Ports    : clk, rst (async, active high), i_en (run), i_clr (sync clear,
//            forces XCK low), o_xck, o_rise_ev, o_fall_ev
// Revision : 1.0 - initial release
// ============================================================================
module m64282_xck_gen #(
    parameter int XCK_DIV = 4
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_en,
    input  wire logic i_clr,
    output logic      o_xck,
    output logic      o_rise_ev,
    output logic      o_fall_ev
);
    localparam int c_CNT_W = (XCK_DIV > 1) ? $clog2(XCK_DIV) : 1;

    logic [c_CNT_W-1:0] r_cnt;
    logic               r_xck;
    logic               w_wrap;

    assign w_wrap = i_en && !i_clr && (r_cnt == c_CNT_W'(XCK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_xck <= 1'b0;
        end else if (i_clr) begin
            r_cnt <= '0;
            r_xck <= 1'b0;
        end else if (w_wrap) begin
            r_cnt <= '0;
            r_xck <= ~r_xck;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_xck     = r_xck;
    assign o_rise_ev = w_wrap && !r_xck;
    assign o_fall_ev = w_wrap &&  r_xck;
endmodule
`default_nettype wire

// File: rtl/m64282_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : m64282_seq
// Purpose  : Capture sequencer for the M64282FP sensor. Resets the sensor,
//            shifts the register image out serially, starts the exposure,
//            waits for READ and streams ADC samples as pixels.
// Ports    : sys_clock, reset (async, active high)
//            host        - m64282_seq_if.slave (cfg/cap_req/busy/pixels/errors)
//            sens_xck/sens_reset/sens_sin/sens_load/sens_start - sensor drive
//            sens_read, adc_data - sensor READ window and ADC sample
// Revision : 1.0 - initial release
// ============================================================================
module m64282_seq
    import m64282_pkg::*;
#(
    parameter int XCK_DIV     = 4,
    parameter int NUM_REGS    = 8,
    parameter int PIX_COUNT   = 16384,
    parameter int ADC_W       = 8,
    parameter int EXP_TIMEOUT = 65535
) (
    input  wire logic             sys_clock,
    input  wire logic             reset,
    m64282_seq_if.slave           host,
    output logic                  sens_xck,
    output logic                  sens_reset,
    output logic                  sens_sin,
    output logic                  sens_load,
    output logic                  sens_start,
    input  wire logic             sens_read,
    input  wire logic [ADC_W-1:0] adc_data
);
    localparam int c_IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int c_PIX_W = $clog2(PIX_COUNT + 1);

    state_t                r_state;
    logic [8*NUM_REGS-1:0] r_cfg;
    logic                  r_busy;
    logic                  r_sreset, r_sin, r_load, r_start;
    logic                  r_pix_valid, r_pix_last;
    logic [ADC_W-1:0]      r_pix_data;
    logic                  r_err_to, r_err_sh;
    logic [3:0]            r_bit_cnt;
    logic [c_IDX_W-1:0]    r_reg_idx;
    logic [15:0]           r_exp_cnt;
    logic [c_PIX_W-1:0]    r_pix_cnt;

    logic                  w_rise, w_fall, w_xck;
    logic [3:0]            w_next_bit;
    logic [c_IDX_W-1:0]    w_next_idx;
    logic [7:0]            w_cur_data, w_next_data;
    logic                  w_timeout;

    m64282_xck_gen #(.XCK_DIV(XCK_DIV)) u_xck (
        .clk       (sys_clock),
        .rst       (reset),
        .i_en      (r_state != IDLE),
        .i_clr     (r_state == DONE),
        .o_xck     (w_xck),
        .o_rise_ev (w_rise),
        .o_fall_ev (w_fall)
    );

    assign w_next_bit  = r_bit_cnt + 4'd1;
    assign w_next_idx  = r_reg_idx + 1'b1;
    assign w_cur_data  = r_cfg[8*r_reg_idx +: 8];
    assign w_next_data = r_cfg[8*w_next_idx +: 8];
    // READ is only looked at on XCK rise; while it is high a timeout is held
    // off so that the pending read still wins on the next rise.
    assign w_timeout   = (r_exp_cnt >= 16'(EXP_TIMEOUT - 1)) && !sens_read;

    always_ff @(posedge sys_clock or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cfg       <= '0;
            r_busy      <= 1'b0;
            r_sreset    <= 1'b0;
            r_sin       <= 1'b0;
            r_load      <= 1'b0;
            r_start     <= 1'b0;
            r_pix_valid <= 1'b0;
            r_pix_last  <= 1'b0;
            r_pix_data  <= '0;
            r_err_to    <= 1'b0;
            r_err_sh    <= 1'b0;
            r_bit_cnt   <= '0;
            r_reg_idx   <= '0;
            r_exp_cnt   <= '0;
            r_pix_cnt   <= '0;
        end else begin
            r_pix_valid <= 1'b0;
            r_pix_last  <= 1'b0;
            case (r_state)
                IDLE: if (host.cap_req) begin
                    r_state   <= RST;
                    r_cfg     <= host.cfg_regs;
                    r_busy    <= 1'b1;
                    r_err_to  <= 1'b0;
                    r_err_sh  <= 1'b0;
                    r_sreset  <= 1'b0;
                    r_bit_cnt <= '0;
                end
                RST: if (w_fall) begin
                    if (r_bit_cnt == 4'(RST_XCK - 1)) begin
                        // Leaving reset also presents the first serial bit.
                        r_sreset  <= 1'b1;
                        r_state   <= LOAD;
                        r_bit_cnt <= '0;
                        r_reg_idx <= '0;
                        r_sin     <= ser_bit('0, r_cfg[7:0], 4'd0);
                        r_load    <= 1'b0;
                    end else begin
                        r_bit_cnt <= w_next_bit;
                    end
                end
                LOAD: if (w_fall) begin
                    if (r_bit_cnt == 4'(SER_BITS - 1)) begin
                        r_load    <= 1'b0;
                        r_bit_cnt <= '0;
                        if (r_reg_idx == c_IDX_W'(NUM_REGS - 1)) begin
                            r_state <= START;
                            r_sin   <= 1'b0;
                            r_start <= 1'b1;
                        end else begin
                            r_reg_idx <= w_next_idx;
                            r_sin     <= ser_bit(ADDR_BITS'(w_next_idx), w_next_data, 4'd0);
                        end
                    end else begin
                        r_bit_cnt <= w_next_bit;
                        r_sin     <= ser_bit(ADDR_BITS'(r_reg_idx), w_cur_data, w_next_bit);
                        r_load    <= (w_next_bit == 4'(SER_BITS - 1));
                    end
                end
                START: if (w_fall) begin
                    r_start   <= 1'b0;
                    r_exp_cnt <= '0;
                    r_state   <= EXPOSE;
                end
                EXPOSE: begin
                    if (w_rise && sens_read) begin
                        r_state   <= READOUT;
                        r_pix_cnt <= '0;
                    end else if (w_fall) begin
                        if (w_timeout) begin
                            r_err_to <= 1'b1;
                            r_state  <= DONE;
                        end else if (r_exp_cnt != 16'hFFFF) begin
                            r_exp_cnt <= r_exp_cnt + 16'd1;
                        end
                    end
                end
                READOUT: if (w_fall) begin
                    if (sens_read) begin
                        r_pix_valid <= 1'b1;
                        r_pix_data  <= adc_data;
                        if (r_pix_cnt == c_PIX_W'(PIX_COUNT - 1)) begin
                            r_pix_last <= 1'b1;
                            r_state    <= DONE;
                        end else begin
                            r_pix_cnt <= r_pix_cnt + 1'b1;
                        end
                    end else begin
                        r_err_sh <= 1'b1;
                        r_state  <= DONE;
                    end
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign sens_xck         = w_xck;
    assign sens_reset       = r_sreset;
    assign sens_sin         = r_sin;
    assign sens_load        = r_load;
    assign sens_start       = r_start;
    assign host.busy        = r_busy;
    assign host.pix_valid   = r_pix_valid;
    assign host.pix_data    = r_pix_data;
    assign host.pix_last    = r_pix_last;
    assign host.err_timeout = r_err_to;
    assign host.err_short   = r_err_sh;
endmodule
`default_nettype wire
